kbd_scan_reader: RTL and testbench

KBD_SCAN_READER -- requirements
Module: kbd_scan_reader

---
 rtl/kbd_scan_reader_pkg.sv | 36 +++
 rtl/kbd_scan_reader_cnt.sv | 28 ++
 rtl/kbd_scan_reader.sv | 131 +++++++++++++
 tb/tb_kbd_scan_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_scan_reader_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, idle/reset
// patterns and small decode helpers.
package kbd_scan_reader_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_RST  = 4'b1110;

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] a;
    a = ~v;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  // Bit position of the (lowest) zero in an active-low vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_next(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/kbd_scan_reader_cnt.sv
// Modulo-MOD prescaler; ceo_o pulses for one CE-qualified cycle per wrap.
module kbd_scan_reader_cnt #(
  parameter int BITS_NUM = 27,
  parameter int MOD      = 100000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic ce_i,
  output logic ceo_o
);

  localparam logic [BITS_NUM-1:0] LAST = BITS_NUM'(MOD - 1);

  logic [BITS_NUM-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ce_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + BITS_NUM'(1);
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ceo_o = ce_i && (cnt_q == LAST);

endmodule

// File: rtl/kbd_scan_reader.sv
// 4x4 keypad scanner: rotating active-low column drive, synchronized row
// sense, press/release debounce on prescaled scan ticks.
module kbd_scan_reader
  import kbd_scan_reader_pkg::*;
#(
  parameter int BITS_NUM = 27,
  parameter int MOD      = 100000,
  parameter int DEB_CNT  = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  output logic [3:0] COL,
  input  logic [3:0] ROW,
  output logic [3:0] KEY,
  output logic       VALID,
  output logic       PRESSED
);

  localparam int            DW       = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  logic          tick;
  logic [3:0]    row_s1_q, row_s2_q;
  state_e        state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;
  logic [3:0]    pat_q, pat_d;
  logic [DW-1:0] deb_q, deb_d;

  kbd_scan_reader_cnt #(
    .BITS_NUM(BITS_NUM),
    .MOD     (MOD)
  ) u_cnt (
    .clk_i(CLK),
    .clr_i(CLR),
    .ce_i (CE),
    .ceo_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    pat_d     = pat_q;
    deb_d     = deb_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (one_low(row_s2_q)) begin
            pat_d   = row_s2_q;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_next(col_q);
          end
        end
        ST_DEBOUNCE: begin
          if (row_s2_q == pat_q) begin
            if (deb_q == DEB_LAST) begin
              key_d     = {low_index(pat_q), low_index(col_q)};
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              state_d   = ST_HELD;
            end else begin
              deb_d = deb_q + DW'(1);
            end
          end else begin
            col_d   = col_next(col_q);
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row_s2_q == ROW_IDLE) begin
            deb_d   = '0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Any activity during release falls back to HELD; no re-acceptance.
          if (row_s2_q == ROW_IDLE) begin
            if (deb_q == DEB_LAST) begin
              pressed_d = 1'b0;
              col_d     = col_next(col_q);
              state_d   = ST_SCAN;
            end else begin
              deb_d = deb_q + DW'(1);
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      row_s1_q  <= ROW_IDLE;
      row_s2_q  <= ROW_IDLE;
      state_q   <= ST_SCAN;
      col_q     <= COL_RST;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      pat_q     <= ROW_IDLE;
      deb_q     <= '0;
    end else begin
      row_s1_q  <= ROW;
      row_s2_q  <= row_s1_q;
      state_q   <= state_d;
      col_q     <= col_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      pat_q     <= pat_d;
      deb_q     <= deb_d;
    end
  end

  assign COL     = col_q;
  assign KEY     = key_q;
  assign VALID   = valid_q;
  assign PRESSED = pressed_q;

endmodule

// File: tb/tb_kbd_scan_reader.sv
// Randomized scoreboard bench for kbd_scan_reader with a physical keypad
// matrix and a tick-level behavioural reference model.
module tb_kbd_scan_reader;

  localparam int MOD = 4;
  localparam int DEB = 3;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        CE  = 1'b1;
  logic [3:0]  COL, ROW, KEY;
  logic        VALID, PRESSED;
  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c pressed

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  int         ce_cnt = 0;
  int         ce_mode = 0;
  bit         last_tick = 0;
  bit         vld_prev = 0;

  int         m_col;
  bit         m_cand_on;
  logic [3:0] m_cand;
  int         m_streak;
  bit         m_pressed;
  int         m_idle;
  logic [3:0] m_key;

  kbd_scan_reader #(.BITS_NUM(8), .MOD(MOD), .DEB_CNT(DEB)) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .CE     (CE),
    .COL    (COL),
    .ROW    (ROW),
    .KEY    (KEY),
    .VALID  (VALID),
    .PRESSED(PRESSED)
  );

  always #5 CLK = ~CLK;

  // Physical matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sense(int col_idx, logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) if (k[i*4+col_idx]) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_pat(int col_idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << col_idx);
  endfunction

  task automatic m_reset();
    m_col = 0; m_cand_on = 0; m_cand = 4'hF; m_streak = 0;
    m_pressed = 0; m_idle = 0; m_key = 4'h0; ce_cnt = 0;
  endtask

  // Reference: a key is accepted after DEB further ticks of the same single-row
  // pattern; it is released after DEB+1 consecutive idle ticks.
  task automatic model_tick();
    logic [3:0] r;
    int ri;
    r = sense(m_col, keys);
    if (m_pressed) begin
      if (r == 4'hF) begin
        m_idle++;
        if (m_idle == DEB + 1) begin
          m_pressed = 0; m_idle = 0; m_col = (m_col + 1) % 4;
        end
      end else m_idle = 0;
    end else if (m_cand_on) begin
      if (r == m_cand) begin
        m_streak++;
        if (m_streak == DEB) begin
          ri = 0;
          for (int i = 3; i >= 0; i--) if (!r[i]) ri = i;
          m_key = {2'(ri), 2'(m_col)};
          exp_q.push_back(m_key);
          m_pressed = 1; m_cand_on = 0; m_idle = 0;
        end
      end else begin
        m_cand_on = 0; m_col = (m_col + 1) % 4;
      end
    end else if ($countones(~r) == 1) begin
      m_cand_on = 1; m_cand = r; m_streak = 0;
    end else begin
      m_col = (m_col + 1) % 4;
    end
  endtask

  task automatic cycle();
    logic ce_now;
    bit   tick;
    ce_now = CE;
    @(posedge CLK);
    tick = 0;
    if (ce_now) begin
      if (ce_cnt == MOD - 1) begin tick = 1; ce_cnt = 0; end
      else ce_cnt++;
    end
    if (tick) model_tick();
    @(negedge CLK);
    if (tick) begin
      chk("col_tick", COL, col_pat(m_col));
      chk("pressed_tick", PRESSED, m_pressed);
      chk("key_tick", KEY, m_key);
    end
    last_tick = tick;
    case (ce_mode)
      0:       CE = 1'b1;
      1:       CE = ($urandom_range(3) != 0);
      default: CE = 1'b0;
    endcase
  endtask

  task automatic tick_wait();
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (last_tick) return;
    end
    n_chk++; n_fail++;
    $display("FAIL tick_timeout: no scan tick within 100 cycles");
  endtask

  task automatic wait_cand();
    for (int i = 0; i < 40 && !m_cand_on; i++) tick_wait();
    if (!m_cand_on) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cand: model never started debounce");
    end
  endtask

  task automatic wait_pressed();
    for (int i = 0; i < 40 && !m_pressed; i++) tick_wait();
    if (!m_pressed) begin
      n_chk++; n_fail++;
      $display("FAIL wait_pressed: model never accepted a key");
    end
  endtask

  task automatic mid_reset();
    #1 CLR = 1'b1;
    #1;
    chk("rst_col", COL, 4'b1110);
    chk("rst_key", KEY, 4'h0);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_pressed", PRESSED, 1'b0);
    keys = 16'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    m_reset();
  endtask

  // Scoreboard monitor: each VALID pulse consumes one expected key.
  always @(negedge CLK) begin
    if (VALID) begin
      chk("valid_gap", vld_prev, 1'b0);
      if (exp_q.size() == 0) chk("unexpected_valid", VALID, 1'b0);
      else chk("key_on_valid", KEY, exp_q.pop_front());
    end
    vld_prev = VALID;
  end

  initial begin
    logic [3:0] frozen;
    m_reset();
    #1 CLR = 1'b1;
    #1;
    chk("rst_col", COL, 4'b1110);
    chk("rst_key", KEY, 4'h0);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_pressed", PRESSED, 1'b0);
    @(negedge CLK);
    CLR = 1'b0;

    // Idle rotation
    repeat (20) tick_wait();

    // CE low freezes the scan
    ce_mode = 2;
    cycle();
    frozen = col_pat(m_col);
    repeat (12) cycle();
    chk("ce_freeze_col", COL, frozen);
    ce_mode = 0;
    cycle();

    // Single key row 2 / column 1
    keys = 16'h1 << (2*4 + 1);
    wait_pressed();
    repeat (4) tick_wait();
    chk("key_r2c1", KEY, 4'b1001);
    chk("col_held_r2c1", COL, 4'b1101);
    keys = 16'h0;
    repeat (8) tick_wait();

    // Bounce: released right after detection
    keys = 16'h1 << (1*4 + 3);
    wait_cand();
    keys = 16'h0;
    repeat (5) tick_wait();

    // Held key with a one-tick release glitch, then a full release
    keys = 16'h1;
    wait_pressed();
    keys = 16'h0;
    tick_wait();
    keys = 16'h1;
    repeat (3) tick_wait();
    chk("pressed_after_glitch", PRESSED, 1'b1);
    keys = 16'h0;
    repeat (6) tick_wait();
    chk("pressed_after_release", PRESSED, 1'b0);

    // Two rows low in one column are ignored
    keys = (16'h1 << (0*4 + 2)) | (16'h1 << (2*4 + 2));
    repeat (12) tick_wait();
    keys = 16'h0;
    repeat (2) tick_wait();

    // Reset in the middle of debounce
    keys = 16'h1 << (3*4 + 2);
    wait_cand();
    mid_reset();
    repeat (6) tick_wait();

    // Randomized key activity with random CE gaps
    ce_mode = 1;
    for (int t = 0; t < 300; t++) begin
      tick_wait();
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0:       keys = 16'h0;
          3:       keys = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
          default: keys = 16'h1 << $urandom_range(15);
        endcase
      end
    end
    ce_mode = 0;
    keys = 16'h0;
    repeat (10) tick_wait();
    chk("pending_valid", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
